// File: rtl/chacha20_block_sched_if.sv
// ChaCha20 block scheduler bus: job control, quarter-round
// engine handshake and keystream block stream.
interface chacha20_block_sched_if;
    logic         start;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter_init;
    logic [7:0]   num_blocks;
    logic         busy;
    logic         qr_start;
    logic [31:0]  qr_a_out;
    logic [31:0]  qr_b_out;
    logic [31:0]  qr_c_out;
    logic [31:0]  qr_d_out;
    logic         qr_done;
    logic [31:0]  qr_a_in;
    logic [31:0]  qr_b_in;
    logic [31:0]  qr_c_in;
    logic [31:0]  qr_d_in;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic [7:0]   blk_index;
    logic         job_done;

    modport master (
        input  start, key, nonce, counter_init, num_blocks,
        input  qr_done, qr_a_in, qr_b_in, qr_c_in, qr_d_in,
        input  blk_ready,
        output busy, qr_start,
        output qr_a_out, qr_b_out, qr_c_out, qr_d_out,
        output blk_valid, blk_data, blk_index, job_done
    );

    modport slave (
        output start, key, nonce, counter_init, num_blocks,
        output qr_done, qr_a_in, qr_b_in, qr_c_in, qr_d_in,
        output blk_ready,
        input  busy, qr_start,
        input  qr_a_out, qr_b_out, qr_c_out, qr_d_out,
        input  blk_valid, blk_data, blk_index, job_done
    );
endinterface

// File: rtl/chacha20_block_sched.sv
// ChaCha20 block scheduler: sequences quarter rounds through an
// external engine, adds the feed-forward and streams blocks.
module chacha20_block_sched #(
    parameter int ROUNDS = 20
) (
    input logic clk,
    input logic rst_n,
    chacha20_block_sched_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FEED, OUT} state_t;
    localparam logic [3:0] DR_LAST = 4'(ROUNDS / 2 - 1);

    state_t      state;
    logic [31:0] s [16];
    logic [31:0] iw [16];
    logic [31:0] ctr;
    logic [7:0]  nblk;
    logic [2:0]  qidx;
    logic [3:0]  dr;
    logic [31:0] qop [4];

    logic [31:0] i_new [16];
    logic [31:0] i_nxt [16];
    logic [31:0] s_wb [16];
    logic [31:0] src [16];
    logic [2:0]  q_nx;
    logic [31:0] op [4];

    // lane selects the row; diagonals shift the column by the lane
    function automatic logic [3:0] sel(
        input logic [2:0] q,
        input logic [1:0] lane
    );
        logic [1:0] col;
        col = q[1:0] + (q[2] ? lane : 2'd0);
        return {lane, col};
    endfunction

    always_comb begin
        i_new[0] = 32'h61707865;
        i_new[1] = 32'h3320646e;
        i_new[2] = 32'h79622d32;
        i_new[3] = 32'h6b206574;
        for (int k = 0; k < 8; k++)
            i_new[4 + k] = bus.key[32 * k +: 32];
        i_new[12] = bus.counter_init;
        for (int n = 0; n < 3; n++)
            i_new[13 + n] = bus.nonce[32 * n +: 32];
        i_nxt = iw;
        i_nxt[12] = ctr + 32'd1;
        s_wb = s;
        s_wb[sel(qidx, 2'd0)] = bus.qr_a_in;
        s_wb[sel(qidx, 2'd1)] = bus.qr_b_in;
        s_wb[sel(qidx, 2'd2)] = bus.qr_c_in;
        s_wb[sel(qidx, 2'd3)] = bus.qr_d_in;
    end

    // operands for the next ISSUE, taken from the state being loaded
    always_comb begin
        src = i_new;
        q_nx = 3'd0;
        if (state == WAIT) begin
            src = s_wb;
            q_nx = qidx + 3'd1;
        end else if (state == OUT) begin
            src = i_nxt;
        end
        for (int l = 0; l < 4; l++)
            op[l] = src[sel(q_nx, 2'(l))];
    end

    assign bus.busy = (state != IDLE);
    assign bus.qr_a_out = qop[0];
    assign bus.qr_b_out = qop[1];
    assign bus.qr_c_out = qop[2];
    assign bus.qr_d_out = qop[3];

    always_comb begin
        for (int i = 0; i < 16; i++)
            bus.blk_data[32 * i +: 32] = s[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ctr <= '0;
            nblk <= '0;
            qidx <= '0;
            dr <= '0;
            for (int i = 0; i < 16; i++) begin
                s[i] <= '0;
                iw[i] <= '0;
            end
            for (int l = 0; l < 4; l++)
                qop[l] <= '0;
            bus.qr_start <= 1'b0;
            bus.blk_valid <= 1'b0;
            bus.blk_index <= '0;
            bus.job_done <= 1'b0;
        end else begin
            bus.job_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.num_blocks == 8'd0) begin
                            bus.job_done <= 1'b1;
                        end else begin
                            s <= i_new;
                            iw <= i_new;
                            ctr <= bus.counter_init;
                            nblk <= bus.num_blocks;
                            qidx <= '0;
                            dr <= '0;
                            bus.blk_index <= '0;
                            qop <= op;
                            bus.qr_start <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    bus.qr_start <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.qr_done) begin
                        s <= s_wb;
                        if (qidx != 3'd7 || dr != DR_LAST) begin
                            qidx <= q_nx;
                            if (qidx == 3'd7)
                                dr <= dr + 4'd1;
                            qop <= op;
                            bus.qr_start <= 1'b1;
                            state <= ISSUE;
                        end else begin
                            state <= FEED;
                        end
                    end
                end
                FEED: begin
                    for (int i = 0; i < 16; i++)
                        s[i] <= s[i] + iw[i];
                    bus.blk_valid <= 1'b1;
                    state <= OUT;
                end
                OUT: begin
                    if (bus.blk_ready) begin
                        bus.blk_valid <= 1'b0;
                        if (bus.blk_index == nblk - 8'd1) begin
                            bus.job_done <= 1'b1;
                            state <= IDLE;
                        end else begin
                            ctr <= ctr + 32'd1;
                            bus.blk_index <= bus.blk_index + 8'd1;
                            iw <= i_nxt;
                            s <= i_nxt;
                            qidx <= '0;
                            dr <= '0;
                            qop <= op;
                            bus.qr_start <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chacha20_block_sched.sv
// Bench for chacha20_block_sched: QR engine model, ChaCha20
// reference and per-scenario checks.
module tb_chacha20_block_sched;
    localparam int ROUNDS = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chacha20_block_sched_if bus();

    chacha20_block_sched #(.ROUNDS(ROUNDS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [127:0] exp_ops[$];
    int max_delay = 0;
    bit stale_done = 1'b0;
    int n_qr = 0;
    int n_valid = 0;
    int n_jobdone = 0;
    bit pend = 1'b0;
    int wait_cnt = 0;
    logic [127:0] cur_ops;
    logic [127:0] eop;
    logic [127:0] res;
    logic prev_valid = 1'b0;
    logic [255:0] rfc_key;
    logic [95:0] rfc_nonce;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr_fn(
        input logic [31:0] a, b, c, d
    );
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Reference block; also queues the operand tuples the scheduler must issue
    task automatic ref_block(
        input logic [255:0] k,
        input logic [95:0] n,
        input logic [31:0] c,
        output logic [511:0] blk
    );
        logic [31:0] init [16];
        logic [31:0] x [16];
        int qt [8][4];
        logic [127:0] r;
        qt = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14},
               '{3, 7, 11, 15}, '{0, 5, 10, 15}, '{1, 6, 11, 12},
               '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        init[0] = 32'h61707865;
        init[1] = 32'h3320646e;
        init[2] = 32'h79622d32;
        init[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) init[4 + i] = k[32 * i +: 32];
        init[12] = c;
        for (int i = 0; i < 3; i++) init[13 + i] = n[32 * i +: 32];
        x = init;
        for (int d = 0; d < ROUNDS / 2; d++) begin
            for (int q = 0; q < 8; q++) begin
                exp_ops.push_back({x[qt[q][0]], x[qt[q][1]],
                                   x[qt[q][2]], x[qt[q][3]]});
                r = qr_fn(x[qt[q][0]], x[qt[q][1]], x[qt[q][2]], x[qt[q][3]]);
                {x[qt[q][0]], x[qt[q][1]], x[qt[q][2]], x[qt[q][3]]} = r;
            end
        end
        for (int i = 0; i < 16; i++) blk[32 * i +: 32] = x[i] + init[i];
    endtask

    // Quarter-round engine with configurable latency
    always @(negedge clk) begin
        bus.qr_done = stale_done;
        if (!rst_n) begin
            pend = 1'b0;
            exp_ops.delete();
        end else if (bus.qr_start) begin
            n_qr++;
            n_checks++;
            if (pend) begin
                n_fail++;
                $display("FAIL qr_start_in_wait: qr_start=1 at qr #%0d, required 0", n_qr);
            end
            cur_ops = {bus.qr_a_out, bus.qr_b_out, bus.qr_c_out, bus.qr_d_out};
            n_checks++;
            if (exp_ops.size() == 0) begin
                n_fail++;
                $display("FAIL qr_order: unexpected qr #%0d ops %h, required none", n_qr, cur_ops);
            end else begin
                eop = exp_ops.pop_front();
                if (cur_ops !== eop) begin
                    n_fail++;
                    $display("FAIL qr_order: qr #%0d ops %h, required %h", n_qr, cur_ops, eop);
                end
            end
            pend = 1'b1;
            wait_cnt = int'($urandom_range(max_delay, 0));
        end else if (pend) begin
            n_checks++;
            if ({bus.qr_a_out, bus.qr_b_out, bus.qr_c_out, bus.qr_d_out} !== cur_ops) begin
                n_fail++;
                $display("FAIL qr_operand_stable: ops %h, required %h",
                         {bus.qr_a_out, bus.qr_b_out, bus.qr_c_out, bus.qr_d_out}, cur_ops);
            end
            if (wait_cnt == 0) begin
                res = qr_fn(cur_ops[127:96], cur_ops[95:64], cur_ops[63:32], cur_ops[31:0]);
                {bus.qr_a_in, bus.qr_b_in, bus.qr_c_in, bus.qr_d_in} = res;
                bus.qr_done = 1'b1;
                pend = 1'b0;
            end else begin
                wait_cnt--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.job_done) n_jobdone++;
            if (bus.blk_valid && !prev_valid) n_valid++;
        end
        prev_valid = bus.blk_valid;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(
        input logic [255:0] k,
        input logic [95:0] n,
        input logic [31:0] c,
        input logic [7:0] nb
    );
        tick();
        bus.key = k;
        bus.nonce = n;
        bus.counter_init = c;
        bus.num_blocks = nb;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.key = '0;
        bus.nonce = '0;
        bus.counter_init = '0;
        bus.num_blocks = '0;
        bus.blk_ready = 1'b0;
        rst_n = 1'b0;
        #23;
        n_checks++;
        if ({bus.busy, bus.qr_start, bus.blk_valid, bus.job_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/qr_start/valid/done=%b, required 0000",
                     {bus.busy, bus.qr_start, bus.blk_valid, bus.job_done});
        end
        n_checks++;
        if ({bus.blk_data, bus.blk_index} !== 520'h0) begin
            n_fail++;
            $display("FAIL reset_data: blk_data=%h idx=%h, required 0", bus.blk_data, bus.blk_index);
        end
        n_checks++;
        if ({bus.qr_a_out, bus.qr_b_out, bus.qr_c_out, bus.qr_d_out} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_ops: ops=%h, required 0",
                     {bus.qr_a_out, bus.qr_b_out, bus.qr_c_out, bus.qr_d_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({bus.busy, bus.blk_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: busy/valid=%b, required 00", {bus.busy, bus.blk_valid});
        end
    endtask

    task automatic test_rfc();
        logic [511:0] exp;
        int cyc;
        max_delay = 0;
        bus.blk_ready = 1'b1;
        ref_block(rfc_key, rfc_nonce, 32'd1, exp);
        start_job(rfc_key, rfc_nonce, 32'd1, 8'd1);
        cyc = 1;
        while (!bus.blk_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc !== 162) begin
            n_fail++;
            $display("FAIL rfc_latency: blk_valid at cycle %0d, required 162", cyc);
        end
        n_checks++;
        if ({bus.blk_data[511:480], bus.blk_data[63:0]} !== 96'h4e3c50a2_15593bd1_e4e7f110) begin
            n_fail++;
            $display("FAIL rfc_words: w15/w1/w0=%h %h %h, required 4e3c50a2 15593bd1 e4e7f110",
                     bus.blk_data[511:480], bus.blk_data[63:32], bus.blk_data[31:0]);
        end
        n_checks++;
        if (bus.blk_data !== exp) begin
            n_fail++;
            $display("FAIL rfc_block: %h, required %h", bus.blk_data, exp);
        end
        tick();
        n_checks++;
        if ({bus.job_done, bus.blk_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rfc_done: done/valid=%b, required 10", {bus.job_done, bus.blk_valid});
        end
        tick();
        n_checks++;
        if ({bus.busy, bus.job_done, 32'(exp_ops.size())} !== 34'h0) begin
            n_fail++;
            $display("FAIL rfc_idle: busy=%b done=%b ops_left=%0d, required 0 0 0",
                     bus.busy, bus.job_done, exp_ops.size());
        end
    endtask

    task automatic test_wrap();
        logic [255:0] k;
        logic [95:0] n;
        logic [511:0] exp [3];
        int jd0;
        int cyc;
        for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
        for (int i = 0; i < 3; i++) n[32 * i +: 32] = $urandom;
        max_delay = 3;
        bus.blk_ready = 1'b0;
        for (int b = 0; b < 3; b++)
            ref_block(k, n, 32'hfffffffe + 32'(b), exp[b]);
        jd0 = n_jobdone;
        start_job(k, n, 32'hfffffffe, 8'd3);
        for (int b = 0; b < 3; b++) begin
            cyc = 0;
            while (!bus.blk_valid && cyc < 2000) begin
                tick();
                cyc++;
            end
            n_checks++;
            if (bus.blk_index !== 8'(b) || !bus.blk_valid) begin
                n_fail++;
                $display("FAIL wrap_index: valid=%b idx=%0d, required 1 %0d",
                         bus.blk_valid, bus.blk_index, b);
            end
            n_checks++;
            if (bus.blk_data !== exp[b]) begin
                n_fail++;
                $display("FAIL wrap_block%0d: %h, required %h", b, bus.blk_data, exp[b]);
            end
            repeat ($urandom_range(2, 0)) tick();
            bus.blk_ready = 1'b1;
            tick();
            bus.blk_ready = 1'b0;
            n_checks++;
            if (bus.blk_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_valid_drop: valid=%b, required 0", bus.blk_valid);
            end
        end
        repeat (3) tick();
        n_checks++;
        if (n_jobdone - jd0 !== 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_job_done: pulses=%0d busy=%b, required 1 0",
                     n_jobdone - jd0, bus.busy);
        end
    endtask

    task automatic test_backpressure();
        logic [511:0] exp;
        logic [511:0] hold;
        int cyc;
        max_delay = 7;
        bus.blk_ready = 1'b0;
        ref_block(rfc_key, rfc_nonce, 32'd1, exp);
        start_job(rfc_key, rfc_nonce, 32'd1, 8'd1);
        cyc = 0;
        while (!bus.blk_valid && cyc < 3000) begin
            tick();
            cyc++;
        end
        hold = bus.blk_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (bus.blk_valid !== 1'b1 || bus.blk_data !== hold || bus.blk_index !== 8'd0) begin
                n_fail++;
                $display("FAIL bp_stable: cycle %0d valid=%b idx=%0d data %h, required 1 0 %h",
                         i, bus.blk_valid, bus.blk_index, bus.blk_data, hold);
            end
        end
        n_checks++;
        if (hold !== exp) begin
            n_fail++;
            $display("FAIL bp_block: %h, required %h", hold, exp);
        end
        bus.blk_ready = 1'b1;
        tick();
        bus.blk_ready = 1'b0;
        n_checks++;
        if (bus.job_done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: job_done=%b, required 1", bus.job_done);
        end
    endtask

    task automatic test_zero_blocks();
        int q0, v0, j0;
        max_delay = 0;
        q0 = n_qr;
        v0 = n_valid;
        j0 = n_jobdone;
        start_job(rfc_key, rfc_nonce, 32'd7, 8'd0);
        n_checks++;
        if ({bus.job_done, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_done: done/busy=%b, required 10", {bus.job_done, bus.busy});
        end
        repeat (5) tick();
        n_checks++;
        if (n_qr != q0 || n_valid != v0 || n_jobdone - j0 != 1) begin
            n_fail++;
            $display("FAIL zero_quiet: qr=%0d valid=%0d done=%0d, required 0 0 1",
                     n_qr - q0, n_valid - v0, n_jobdone - j0);
        end
    endtask

    task automatic test_start_while_busy();
        logic [255:0] k;
        logic [95:0] n;
        logic [31:0] c;
        logic [511:0] exp;
        int v0, cyc;
        for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
        for (int i = 0; i < 3; i++) n[32 * i +: 32] = $urandom;
        c = $urandom;
        max_delay = 1;
        bus.blk_ready = 1'b1;
        v0 = n_valid;
        ref_block(k, n, c, exp);
        start_job(k, n, c, 8'd1);
        cyc = 0;
        while (n_qr < 10 && cyc < 100) begin
            tick();
            cyc++;
        end
        bus.key = ~k;
        bus.nonce = ~n;
        bus.counter_init = c + 32'd9;
        bus.num_blocks = 8'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.blk_valid && cyc < 2000) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (bus.blk_data !== exp || bus.blk_index !== 8'd0) begin
            n_fail++;
            $display("FAIL busy_start_block: idx=%0d %h, required 0 %h",
                     bus.blk_index, bus.blk_data, exp);
        end
        repeat (5) tick();
        n_checks++;
        if (bus.busy !== 1'b0 || n_valid - v0 != 1) begin
            n_fail++;
            $display("FAIL busy_start_once: busy=%b blocks=%0d, required 0 1",
                     bus.busy, n_valid - v0);
        end
    endtask

    task automatic test_reset_mid();
        logic [511:0] exp;
        int cyc, q0;
        max_delay = 2;
        bus.blk_ready = 1'b0;
        ref_block(rfc_key, rfc_nonce, 32'd1, exp);
        q0 = n_qr;
        start_job(rfc_key, rfc_nonce, 32'd1, 8'd1);
        cyc = 0;
        while (n_qr - q0 < 35 && cyc < 1000) begin
            tick();
            cyc++;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.qr_start, bus.blk_valid, bus.job_done, bus.blk_index} !== 12'h0 ||
            {bus.qr_a_out, bus.qr_b_out, bus.qr_c_out, bus.qr_d_out} !== 128'h0 ||
            bus.blk_data !== 512'h0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: busy=%b qs=%b v=%b d=%b idx=%0d a=%h, required all 0",
                     bus.busy, bus.qr_start, bus.blk_valid, bus.job_done, bus.blk_index, bus.qr_a_out);
        end
        stale_done = 1'b1;
        bus.blk_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({bus.busy, bus.blk_valid, bus.qr_start} !== 3'b000) begin
                n_fail++;
                $display("FAIL stale_inputs: busy/valid/qr_start=%b, required 000",
                         {bus.busy, bus.blk_valid, bus.qr_start});
            end
        end
        stale_done = 1'b0;
        tick();
        max_delay = 0;
        ref_block(rfc_key, rfc_nonce, 32'd1, exp);
        start_job(rfc_key, rfc_nonce, 32'd1, 8'd1);
        cyc = 1;
        while (!bus.blk_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc !== 162 || bus.blk_data !== exp) begin
            n_fail++;
            $display("FAIL post_reset_job: cycle %0d data %h, required 162 %h",
                     cyc, bus.blk_data, exp);
        end
        tick();
        bus.blk_ready = 1'b0;
        n_checks++;
        if (bus.job_done !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_done: job_done=%b, required 1", bus.job_done);
        end
    endtask

    initial begin
        for (int b = 0; b < 32; b++) rfc_key[8 * b +: 8] = 8'(b);
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
        test_reset();
        test_rfc();
        test_wrap();
        test_backpressure();
        test_zero_blocks();
        test_start_while_busy();
        test_reset_mid();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/chacha20_block_sched.md
CHACHA20_BLOCK_SCHED -- requirements
Module: chacha20_block_sched

Interface
REQ-001 SHALL have parameter: ROUNDS, 20, total ChaCha rounds per block; even, 2..20; ROUNDS/2 double rounds of 8 quarter rounds each.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  job request, sampled in IDLE only.
- key  in  256  key; word k = key[32k+31:32k], k=0..7.
- nonce  in  96  nonce; word n = nonce[32n+31:32n], n=0..2.
- counter_init  in  32  block counter of first block.
- num_blocks  in  8  blocks to produce in the job.
- busy  out  1  high whenever state != IDLE.
- qr_start  out  1  one-cycle quarter-round request.
- qr_a_out, qr_b_out, qr_c_out, qr_d_out  out  32 each  quarter-round operands.
- qr_done  in  1  quarter-round result valid.
- qr_a_in, qr_b_in, qr_c_in, qr_d_in  in  32 each  quarter-round results.
- blk_valid  out  1  keystream block valid.
- blk_ready  in  1  consumer accepts block.
- blk_data  out  512  block; word i = blk_data[32i+31:32i].
- blk_index  out  8  zero-based block number within the job.
- job_done  out  1  one-cycle pulse when the job completes.

Function
REQ-003 SHALL hold a 16-word state S and a 16-word initial copy I. Matrix view: row = i/4, column = i%4.
REQ-004 SHALL build I as follows:
- words 0..3 = 61707865, 3320646e, 79622d32, 6b206574.
- words 4..11 = key words 0..7.
- word 12 = block counter.
- words 13..15 = nonce words 0..2.
REQ-005 SHALL use states IDLE, ISSUE, WAIT, FEED, OUT.
REQ-006 IDLE: on start=1, SHALL latch key, nonce and num_blocks, set ctr=counter_init, load S=I, set qidx=0, dr=0 and blk_index=0, and go to ISSUE.
REQ-007 IDLE with start=1 and num_blocks=0: SHALL pulse job_done in the next cycle and stay in IDLE. No qr_start and no blk_valid are produced.
REQ-008 SHALL select operands (a,b,c,d) by qidx:
- qidx 0..3, columns: (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
- qidx 4..7, diagonals: (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
REQ-009 ISSUE: SHALL drive qr_start=1 for exactly one cycle with the selected S words on qr_*_out, then go to WAIT.
REQ-010 WAIT: qr_*_out SHALL stay stable until qr_done. On qr_done=1, SHALL write qr_*_in back to the same four indices at that edge.
REQ-011 Sequencing after each write-back:
- qidx<7: qidx+1, go to ISSUE.
- qidx=7 and dr<ROUNDS/2-1: qidx=0, dr+1, go to ISSUE.
- otherwise: go to FEED.
REQ-012 qr_done SHALL be ignored in every state except WAIT. The engine latency is unbounded; there is no timeout.
REQ-013 FEED: SHALL set S[i]=S[i]+I[i] mod 2^32 for every i in one cycle, then go to OUT.
REQ-014 OUT: blk_valid=1 and blk_data=S. blk_data and blk_index SHALL stay stable while blk_valid=1 and blk_ready=0.
REQ-015 OUT with blk_ready=1 (handshake): SHALL deassert blk_valid in the next cycle. Then:
- blocks remain: ctr=ctr+1 mod 2^32, blk_index+1, S=I rebuilt with the new ctr, qidx=0, dr=0, go to ISSUE.
- last block: pulse job_done, go to IDLE.
REQ-016 Counter wrap: ctr=ffffffff SHALL roll to 00000000 without any flag or stall.
REQ-017 Latency: with qr_done asserted in the cycle after qr_start, blk_valid SHALL rise 8*ROUNDS+2 cycles after the start edge (162 cycles at ROUNDS=20).
REQ-018 start, key, nonce, counter_init and num_blocks SHALL be ignored while busy=1.

Reset
REQ-019 On rst_n=0, SHALL immediately go to IDLE, including mid-job, and clear all of:
- busy, qr_start, blk_valid, job_done.
- qr_*_out, blk_data, blk_index.
- ctr, qidx, dr, S, I.
REQ-020 After reset release, a stale qr_done or blk_ready SHALL have no effect. The first accepted start SHALL begin a fresh job.

Verification
REQ-021 RFC 8439 sec 2.3.2 vector with single-cycle reference QR engine:
- stimulus: key words 03020100..1f1e1d1c, nonce words 09000000, 4a000000, 00000000, counter_init=1, num_blocks=1, blk_ready=1.
- response: blk_data word0=e4e7f110, word1=15593bd1, word15=4e3c50a2; blk_valid at cycle 162; job_done pulse follows.
REQ-022 Multi-block with counter wrap:
- stimulus: counter_init=fffffffe, num_blocks=3.
- response: word12 of I = fffffffe, ffffffff, 00000000; blk_index = 0, 1, 2; exactly one job_done.
REQ-023 Backpressure and engine stall:
- stimulus: blk_ready held 0 for 10 cycles; qr_done delayed randomly 0..7 cycles.
- response: blk_data stable throughout; same result as REQ-021; qr_start never high in WAIT.
REQ-024 num_blocks=0 and start while busy:
- num_blocks=0: job_done only, with no qr_start and no blk_valid.
- start pulsed mid-job with different inputs: output unchanged.
REQ-025 Reset mid-job:
- stimulus: rst_n=0 during dr=4 WAIT, then a new start.
- response: all outputs 0 immediately; the new job matches REQ-021 exactly.
REQ-026 Column and diagonal order:
- stimulus: monitor the qr_*_out indices per qr_start.
- response: the sequence is the REQ-008 order repeated ROUNDS/2 times.
